// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive path: sequencer states, stereo frame layout
// and a small width helper for counters and FIFO pointers.
package i2s_pkg;

    localparam int I2S_WORD_LEN = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rx_seq_state_e;

    typedef struct packed {
        logic [I2S_WORD_LEN-1:0] left;
        logic [I2S_WORD_LEN-1:0] right;
    } stereo_frame_t;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/i2s_stereo_fifo.sv
// Small stereo frame FIFO with wrap-bit pointers; a push into a full FIFO is
// still accepted when a pop happens in the same cycle, otherwise it is dropped.
module i2s_stereo_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  stereo_frame_t frame_i,
    input  logic          pop_i,
    output stereo_frame_t frame_o,
    output logic          empty_o,
    output logic          drop_o
);

    localparam int AW = clog2_min1(DEPTH);

    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    stereo_frame_t mem_q [DEPTH];
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign frame_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage is reset so the head outputs read zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= frame_i;
        end
    end

endmodule

// File: rtl/i2s_rx_sequencer.sv
// Master-mode I2S receive sequencer: bclk/lrclk generation, run/drain control,
// left/right pairing into stereo frames and a frame FIFO towards the consumer.
module i2s_rx_sequencer
    import i2s_pkg::*;
#(
    parameter int CLK_DIV    = 14,
    parameter int WORD_LEN   = I2S_WORD_LEN,
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                bclk_o,
    output logic                lrclk_o,
    output logic                rx_enable_o,
    input  logic [WORD_LEN-1:0] rx_data_i,
    input  logic                rx_new_sample_i,
    output logic                frame_valid_o,
    input  logic                frame_ready_i,
    output logic [WORD_LEN-1:0] frame_left_o,
    output logic [WORD_LEN-1:0] frame_right_o,
    output logic                overflow_o,
    input  logic                overflow_clr_i,
    output logic                busy_o
);

    localparam int HALF_DIV   = CLK_DIV / 2;
    localparam int HALF_FRAME = FRAME_LEN / 2;
    localparam int DIV_W      = clog2_min1(HALF_DIV);
    localparam int BIT_W      = clog2_min1(HALF_FRAME);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(HALF_FRAME - 1);

    rx_seq_state_e       state_q;
    rx_seq_state_e       state_d;
    logic                run_entry;
    logic                busy_d;
    logic                busy_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic                bclk_q;
    logic                lrclk_q;
    logic                div_tc;
    logic                left_evt;
    logic                right_evt;
    logic                pair_evt;
    logic                hold_full_q;
    logic [WORD_LEN-1:0] hold_left_q;
    logic                drain_done_q;
    logic                overflow_q;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_drop;
    stereo_frame_t       push_frame;
    stereo_frame_t       head_frame;

    assign div_tc    = busy_q && (div_cnt_q == DIV_LAST);
    assign left_evt  = busy_q && rx_new_sample_i && lrclk_q;
    assign right_evt = busy_q && rx_new_sample_i && !lrclk_q;
    assign pair_evt  = right_evt && hold_full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // DRAIN waits for the frame's right word, then only leaves while bclk is low
    // (or about to fall) so no high half-period gets cut short.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (stop_i)  state_d = DRAIN;
            DRAIN:   if ((pair_evt || drain_done_q) && (!bclk_q || div_tc)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d    = (state_d != IDLE);
        run_entry = (state_q == IDLE) && (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= 1'b0;
        else         busy_q <= busy_d;
    end

    // lrclk advances only on a bclk falling edge, after HALF_FRAME falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
        end else if (!busy_d || run_entry) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
        end else if (div_tc) begin
            div_cnt_q <= '0;
            bclk_q    <= !bclk_q;
            if (bclk_q) begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_q <= '0;
                    lrclk_q   <= !lrclk_q;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                end
            end
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Right words with no held left word (e.g. the receiver's first pulse) are discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_full_q  <= 1'b0;
            hold_left_q  <= '0;
            drain_done_q <= 1'b0;
        end else if (run_entry) begin
            hold_full_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            if (left_evt) begin
                hold_left_q <= rx_data_i;
                hold_full_q <= 1'b1;
            end else if (pair_evt) begin
                hold_full_q <= 1'b0;
            end
            if (state_d == IDLE)                    drain_done_q <= 1'b0;
            else if (state_q == DRAIN && pair_evt)  drain_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             overflow_q <= 1'b0;
        else if (fifo_drop)      overflow_q <= 1'b1;
        else if (overflow_clr_i) overflow_q <= 1'b0;
    end

    assign push_frame.left  = hold_left_q;
    assign push_frame.right = rx_data_i;
    assign fifo_pop         = !fifo_empty && frame_ready_i;

    i2s_stereo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pair_evt),
        .frame_i (push_frame),
        .pop_i   (fifo_pop),
        .frame_o (head_frame),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign bclk_o        = bclk_q;
    assign lrclk_o       = lrclk_q;
    assign busy_o        = busy_q;
    assign rx_enable_o   = busy_q;
    assign overflow_o    = overflow_q;
    assign frame_valid_o = !fifo_empty;
    assign frame_left_o  = head_frame.left;
    assign frame_right_o = head_frame.right;

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Directed bench for i2s_rx_sequencer with a word-level receiver model that
// delivers each half's word on the lrclk edge ending that half.
module tb_i2s_rx_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        stop_i;
    logic        bclk_o;
    logic        lrclk_o;
    logic        rx_enable_o;
    logic [23:0] rx_data_i;
    logic        rx_new_sample_i;
    logic        frame_valid_o;
    logic        frame_ready_i;
    logic [23:0] frame_left_o;
    logic [23:0] frame_right_o;
    logic        overflow_o;
    logic        overflow_clr_i;
    logic        busy_o;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   tx_frame     = 0;
    bit   rx_is_right  = 1'b0;
    logic lr_prev      = 1'b0;
    logic en_prev      = 1'b0;

    i2s_rx_sequencer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .bclk_o          (bclk_o),
        .lrclk_o         (lrclk_o),
        .rx_enable_o     (rx_enable_o),
        .rx_data_i       (rx_data_i),
        .rx_new_sample_i (rx_new_sample_i),
        .frame_valid_o   (frame_valid_o),
        .frame_ready_i   (frame_ready_i),
        .frame_left_o    (frame_left_o),
        .frame_right_o   (frame_right_o),
        .overflow_o      (overflow_o),
        .overflow_clr_i  (overflow_clr_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] frame_left(input int n);
        if (n == 0) return 24'hABCDEF;
        return 24'h100000 + 24'(n);
    endfunction

    function automatic logic [23:0] frame_right(input int n);
        if (n == 0) return 24'h123456;
        return 24'h200000 + 24'(n);
    endfunction

    // Receiver: one spurious pulse when enabled, then a word at every lrclk edge.
    initial begin
        rx_new_sample_i = 1'b0;
        rx_data_i       = '0;
        forever begin
            @(negedge clk_i);
            rx_new_sample_i = 1'b0;
            rx_is_right     = 1'b0;
            if (rx_enable_o && !en_prev) begin
                rx_new_sample_i = 1'b1;
                rx_data_i       = 24'hDEAD00;
            end else if (rx_enable_o && (lrclk_o != lr_prev)) begin
                rx_new_sample_i = 1'b1;
                if (lrclk_o) begin
                    rx_data_i = frame_left(tx_frame);
                end else begin
                    rx_data_i   = frame_right(tx_frame);
                    rx_is_right = 1'b1;
                    tx_frame++;
                end
            end
            lr_prev = lrclk_o;
            en_prev = rx_enable_o;
        end
    end

    task automatic pulse_start();
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk_i); stop_i = 1'b1;
        @(negedge clk_i); stop_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        frame_ready_i = 1'b0; overflow_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if ({bclk_o, lrclk_o, rx_enable_o, busy_o, frame_valid_o, overflow_o} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {bclk_o, lrclk_o, rx_enable_o, busy_o, frame_valid_o, overflow_o});
        end
        tests_run++;
        if ({frame_left_o, frame_right_o} !== 48'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {frame_left_o, frame_right_o});
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_first_frame();
        int guard = 0;
        pulse_start();
        repeat (100) @(negedge clk_i);
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL start_busy: got %b expected 1", busy_o);
        end
        tests_run++;
        if (frame_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_discard: valid got %b expected 0", frame_valid_o);
        end
        while (frame_valid_o !== 1'b1 && guard < 1500) begin
            @(negedge clk_i); guard++;
        end
        tests_run++;
        if (frame_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_valid: got %b expected 1", frame_valid_o);
        end
        tests_run++;
        if (frame_left_o !== 24'hABCDEF || frame_right_o !== 24'h123456) begin
            tests_failed++;
            $display("[TB] FAIL first_frame: got %h/%h expected abcdef/123456",
                     frame_left_o, frame_right_o);
        end
    endtask

    task automatic test_overflow();
        int guard = 0;
        while (overflow_o !== 1'b1 && guard < 5000) begin
            @(negedge clk_i); guard++;
        end
        tests_run++;
        if (overflow_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_set: got %b expected 1", overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (frame_valid_o !== 1'b1 || frame_left_o !== frame_left(i) ||
                frame_right_o !== frame_right(i)) begin
                tests_failed++;
                $display("[TB] FAIL overflow_order[%0d]: got v=%b %h/%h expected v=1 %h/%h", i,
                         frame_valid_o, frame_left_o, frame_right_o, frame_left(i), frame_right(i));
            end
            frame_ready_i = 1'b1;
            @(negedge clk_i);
            frame_ready_i = 1'b0;
        end
        tests_run++;
        if (frame_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fifth_dropped: valid got %b expected 0", frame_valid_o);
        end
        tests_run++;
        if (overflow_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow_o);
        end
        overflow_clr_i = 1'b1;
        @(negedge clk_i);
        overflow_clr_i = 1'b0;
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overflow_clear: got %b expected 0", overflow_o);
        end
    endtask

    task automatic test_full_pop_push();
        int guard = 0;
        do begin
            @(negedge clk_i); #1; guard++;
        end while (!(rx_is_right && tx_frame == 10) && guard < 6000);
        tests_run++;
        if (frame_valid_o !== 1'b1 || frame_left_o !== frame_left(5)) begin
            tests_failed++;
            $display("[TB] FAIL full_head: got v=%b %h expected v=1 %h",
                     frame_valid_o, frame_left_o, frame_left(5));
        end
        frame_ready_i = 1'b1;
        @(negedge clk_i);
        frame_ready_i = 1'b0;
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_pop_no_overflow: got %b expected 0", overflow_o);
        end
        for (int i = 6; i < 10; i++) begin
            tests_run++;
            if (frame_valid_o !== 1'b1 || frame_left_o !== frame_left(i) ||
                frame_right_o !== frame_right(i)) begin
                tests_failed++;
                $display("[TB] FAIL full_pop_order[%0d]: got v=%b %h/%h expected v=1 %h/%h", i,
                         frame_valid_o, frame_left_o, frame_right_o, frame_left(i), frame_right(i));
            end
            frame_ready_i = 1'b1;
            @(negedge clk_i);
            frame_ready_i = 1'b0;
        end
        tests_run++;
        if (frame_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_pop_count: valid got %b expected 0", frame_valid_o);
        end
    endtask

    task automatic test_stop_drain();
        int guard = 0;
        do begin
            @(negedge clk_i); #1; guard++;
        end while (!(rx_is_right && tx_frame == 11) && guard < 2000);
        @(negedge clk_i);
        tests_run++;
        if (frame_left_o !== frame_left(10) || frame_right_o !== frame_right(10)) begin
            tests_failed++;
            $display("[TB] FAIL pre_stop_frame: got %h/%h expected %h/%h",
                     frame_left_o, frame_right_o, frame_left(10), frame_right(10));
        end
        frame_ready_i = 1'b1;
        @(negedge clk_i);
        frame_ready_i = 1'b0;
        repeat (100) @(negedge clk_i);
        pulse_stop();
        guard = 0;
        while (frame_valid_o !== 1'b1 && guard < 2000) begin
            @(posedge clk_i); #1; guard++;
        end
        tests_run++;
        if (frame_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stop_push_idle: got valid=%b busy=%b expected valid=1 busy=0",
                     frame_valid_o, busy_o);
        end
        @(negedge clk_i);
        tests_run++;
        if ({bclk_o, lrclk_o, rx_enable_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL stop_clocks: got %b expected 000", {bclk_o, lrclk_o, rx_enable_o});
        end
        tests_run++;
        if (frame_left_o !== frame_left(11) || frame_right_o !== frame_right(11)) begin
            tests_failed++;
            $display("[TB] FAIL stop_frame: got %h/%h expected %h/%h",
                     frame_left_o, frame_right_o, frame_left(11), frame_right(11));
        end
        repeat (1000) @(negedge clk_i);
        tests_run++;
        if (busy_o !== 1'b0 || bclk_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stop_halted: got busy=%b bclk=%b expected 0/0", busy_o, bclk_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        pulse_start();
        repeat (600) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({bclk_o, lrclk_o, rx_enable_o, busy_o, frame_valid_o, overflow_o} !== 6'b0 ||
            {frame_left_o, frame_right_o} !== 48'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got ctrl=%b data=%h expected 0/0",
                     {bclk_o, lrclk_o, rx_enable_o, busy_o, frame_valid_o, overflow_o},
                     {frame_left_o, frame_right_o});
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        pulse_start();
        while (frame_valid_o !== 1'b1 && guard < 2000) begin
            @(negedge clk_i); guard++;
        end
        tests_run++;
        if (frame_valid_o !== 1'b1 || frame_left_o !== frame_left(12) ||
            frame_right_o !== frame_right(12)) begin
            tests_failed++;
            $display("[TB] FAIL restart_pairing: got v=%b %h/%h expected v=1 %h/%h",
                     frame_valid_o, frame_left_o, frame_right_o, frame_left(12), frame_right(12));
        end
        pulse_stop();
        guard = 0;
        while (busy_o !== 1'b0 && guard < 2000) begin
            @(negedge clk_i); guard++;
        end
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL restart_stop: busy got %b expected 0", busy_o);
        end
    endtask

    task automatic test_periods();
        int   first_rise = -1;
        int   second_rise = -1;
        int   falls = 0;
        int   falls_at_toggle = -1;
        int   lr_toggles = 0;
        int   misaligned = 0;
        logic b_prev;
        logic l_prev;
        @(negedge clk_i);
        start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; stop_i = 1'b0;
        b_prev = bclk_o;
        l_prev = lrclk_o;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk_i); #1;
            if (!b_prev && bclk_o) begin
                if (first_rise < 0)       first_rise = k;
                else if (second_rise < 0) second_rise = k;
            end
            if (b_prev && !bclk_o) falls++;
            if (lrclk_o != l_prev) begin
                lr_toggles++;
                if (!(b_prev && !bclk_o)) misaligned++;
                if (falls_at_toggle < 0) falls_at_toggle = falls;
            end
            b_prev = bclk_o;
            l_prev = lrclk_o;
        end
        tests_run++;
        if (first_rise !== 7) begin
            tests_failed++;
            $display("[TB] FAIL bclk_first_rise: got %0d expected 7", first_rise);
        end
        tests_run++;
        if (second_rise - first_rise !== 14) begin
            tests_failed++;
            $display("[TB] FAIL bclk_period: got %0d expected 14", second_rise - first_rise);
        end
        tests_run++;
        if (falls_at_toggle !== 32) begin
            tests_failed++;
            $display("[TB] FAIL lrclk_falls: got %0d expected 32", falls_at_toggle);
        end
        tests_run++;
        if (lr_toggles !== 2 || misaligned !== 0) begin
            tests_failed++;
            $display("[TB] FAIL lrclk_align: got toggles=%0d misaligned=%0d expected 2/0",
                     lr_toggles, misaligned);
        end
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL start_wins_stop: busy got %b expected 1", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_overflow();
        test_full_pop_push();
        test_stop_drain();
        test_reset_mid_frame();
        test_periods();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
